// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and serial framing levels.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } tx_state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes o_tick
// on the last cycle of each bit, restarting from zero for the next bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tick = i_en && (r_count == LP_LAST);

    // Held at zero outside bit-timed states, so every state or bit change starts fresh.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_count <= '0;
        end else if (!i_en || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed by a registered-output FIFO; 8N1 framing by default,
// even parity bit after the payload when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET_n,
    input  logic [DATA_WIDTH-1:0] i_Fifo_Data,
    input  logic                  i_Fifo_Empty,
    output logic                  o_Fifo_Read_EN,
    output logic                  o_TX,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int               IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LP_LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_next;
    logic                  r_tx, w_tx_next;
    logic                  w_bit_en;
    logic                  w_tick;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity, w_parity_next;
`endif

    assign w_bit_en = !(r_state inside {ST_IDLE, ST_READ, ST_LATCH});

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_CLK    (i_CLK),
        .i_RESET_n(i_RESET_n),
        .i_en     (w_bit_en),
        .o_tick   (w_tick)
    );

    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = r_tx;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!i_Fifo_Empty) w_state_next = ST_READ;
            end
            ST_READ: begin
                w_state_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_shift_next = i_Fifo_Data;
`ifdef UART_TX_PARITY_EN
                w_parity_next = ^i_Fifo_Data;
`endif
                w_tx_next    = UART_START_BIT;
                w_state_next = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LP_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_next    = r_parity;
                        w_state_next = ST_PARITY;
`else
                        w_tx_next    = UART_STOP_BIT;
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = w_shift_next[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_tx_next    = UART_STOP_BIT;
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) w_state_next = ST_IDLE;
            end
            default: begin
                w_tx_next    = UART_STOP_BIT;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    // NOTE: the shift register is a handful of flops, not a RAM, so it is reset too.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= UART_STOP_BIT;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign o_TX           = r_tx;
    assign o_Busy         = (r_state != ST_IDLE);
    assign o_Fifo_Read_EN = (r_state == ST_READ);
    assign o_Done         = (r_state == ST_STOP) && w_tick;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model, frame-position reference model,
// per-cycle output compare and a line decoder for payload/length/gap checks.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int FRAME_LEN_LIT = 44;
    localparam logic [FRAME_BITS-1:0] T1_FRAME_LIT = 11'h4AA;
`else
    localparam int FRAME_BITS = 10;
    localparam int FRAME_LEN_LIT = 40;
    localparam logic [FRAME_BITS-1:0] T1_FRAME_LIT = 10'h2AA;
`endif
    localparam int FRAME_LEN = CPB * FRAME_BITS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          rd_en, tx, busy, done;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW)
    ) dut (
        .i_CLK         (clk),
        .i_RESET_n     (rst_n),
        .i_Fifo_Data   (fifo_data),
        .i_Fifo_Empty  (fifo_empty),
        .o_Fifo_Read_EN(rd_en),
        .o_TX          (tx),
        .o_Busy        (busy),
        .o_Done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: pops on a read request, data presented before the capture edge.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] m_byte;
    initial begin
        fifo_data  = '0;
        fifo_empty = 1'b1;
        m_byte     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rd_en && fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                m_byte    = fifo_data;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Reference model: position within a transfer (-1 idle, 0 pop, 1 latch, 2.. frame).
    int m_pos = -1;
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n)                      m_pos = -1;
            else if (m_pos < 0)              m_pos = fifo_empty ? -1 : 0;
            else if (m_pos == FRAME_LEN + 1) m_pos = -1;
            else                             m_pos++;
        end
    end

    // Returns {rd_en, busy, done, tx} expected at a given position.
    function automatic logic [3:0] model_out(input int pos, input logic [DW-1:0] b);
        int   k;
        int   bi;
        logic t;
        if (pos < 0)  return 4'b0001;
        if (pos == 0) return 4'b1101;
        if (pos == 1) return 4'b0101;
        k  = pos - 2;
        bi = k / CPB;
        if (bi == 0)        t = 1'b0;
        else if (bi <= DW)  t = b[bi-1];
`ifdef UART_TX_PARITY_EN
        else if (bi == DW + 1) t = ^b;
`endif
        else                t = 1'b1;
        return {1'b0, 1'b1, (k == FRAME_LEN - 1), t};
    endfunction

    int   cyc = 0, n_rd = 0, n_done = 0;
    int   last_done_cyc = 0, start_cyc = 0, last_len = 0, last_gap = 0, bit_n = 0;
    bit   in_frame = 1'b0;
    logic prev_tx = 1'b1;
    logic [3:0] exp_o;
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] rx_q[$];

    // Compare and line-decode process, sampling mid-cycle.
    initial begin
        bits = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            exp_o = rst_n ? model_out(m_pos, m_byte) : 4'b0001;
            check("cycle_outputs", {28'd0, rd_en, busy, done, tx}, {28'd0, exp_o});
            if (!rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (rd_en) n_rd++;
                if (!in_frame && prev_tx && !tx) begin
                    in_frame  = 1'b1;
                    start_cyc = cyc;
                    last_gap  = cyc - last_done_cyc - 1;
                    bit_n     = 0;
                end
                if (in_frame && ((cyc - start_cyc) % CPB == CPB / 2) && bit_n < FRAME_BITS) begin
                    bits[bit_n] = tx;
                    bit_n++;
                end
                if (done) begin
                    n_done++;
                    last_done_cyc = cyc;
                    if (in_frame) begin
                        last_len = cyc - start_cyc + 1;
                        rx_q.push_back(bits);
                    end
                    in_frame = 1'b0;
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (n_done < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_timeout", 32'(n_done >= target), 32'd1);
    endtask

    task automatic check_rx(input string name, input logic [DW-1:0] exp_data);
        logic [FRAME_BITS-1:0] f;
        check({name, "_present"}, 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0) begin
            f = rx_q.pop_front();
            check({name, "_data"},  32'(f[DW:1]), 32'(exp_data));
            check({name, "_start"}, 32'(f[0]), 32'd0);
            check({name, "_stop"},  32'(f[FRAME_BITS-1]), 32'd1);
        end
    endtask

    int rd0, d0, c;
    logic [FRAME_BITS-1:0] f;

    initial begin
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx",   32'(tx),    32'd1);
        check("rst_busy", 32'(busy),  32'd0);
        check("rst_rd",   32'(rd_en), 32'd0);
        check("rst_done", 32'(done),  32'd0);
        rst_n = 1'b1;
        tick(3);

        // Single frame 0x55
        fifo_q.push_back(8'h55);
        wait_done(1, 200);
        tick(4);
        check("t1_reads", n_rd, 1);
        check("t1_dones", n_done, 1);
        check("t1_len", last_len, FRAME_LEN_LIT);
        check("t1_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            f = rx_q.pop_front();
            check("t1_frame", 32'(f), 32'(T1_FRAME_LIT));
        end

        // Back-to-back 0xA5, 0x3C
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        wait_done(3, 400);
        tick(4);
        check("t2_reads", n_rd, 3);
        check("t2_gap", last_gap, 3);
        check("t2_len", last_len, FRAME_LEN_LIT);
        check_rx("t2_a5", 8'hA5);
        check_rx("t2_3c", 8'h3C);

        // Idle with empty FIFO
        rd0 = n_rd;
        tick(100);
        check("t3_reads", n_rd, rd0);
        check("t3_tx", 32'(tx), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);

        // Reset during data bit 3 of the first of two frames
        rd0 = n_rd;
        d0  = n_done;
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'h42);
        c = 0;
        while (!in_frame && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("t4_start_timeout", 32'(in_frame), 32'd1);
        tick(16);
        check("t4_pre_tx", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t4_rst_tx", 32'(tx), 32'd1);
        check("t4_rst_busy", 32'(busy), 32'd0);
        tick(3);
        rst_n = 1'b1;
        wait_done(d0 + 1, 200);
        tick(4);
        check("t4_reads", n_rd, rd0 + 2);
        check_rx("t4_42", 8'h42);
        check("t4_no_extra", rx_q.size(), 0);

`ifdef UART_TX_PARITY_EN
        // Parity bit for 0x07 (odd weight -> 1)
        d0 = n_done;
        fifo_q.push_back(8'h07);
        wait_done(d0 + 1, 200);
        tick(4);
        check("t5_len", last_len, 44);
        check("t5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            f = rx_q.pop_front();
            check("t5_frame", 32'(f), 32'h60E);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 217, i_CLK cycles per serial bit; legal range >= 2.
REQ-002 SHALL have parameter: DATA_WIDTH, 8, bits per frame payload.
REQ-003 SHALL have port: i_CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port: i_RESET_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: i_Fifo_Data  input  DATA_WIDTH  registered read data from the upstream FIFO.
REQ-006 SHALL have port: i_Fifo_Empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port: o_Fifo_Read_EN  output  1  one-cycle pop request to the upstream FIFO.
REQ-008 SHALL have port: o_TX  output  1  serial line; idle high.
REQ-009 SHALL have port: o_Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: o_Done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 SHALL implement states IDLE, READ, LATCH, START, DATA, PARITY (macro only), STOP.
REQ-012 IDLE: SHALL move to READ when i_Fifo_Empty=0, else remain in IDLE; i_Fifo_Empty SHALL be ignored in all other states.
REQ-013 READ: SHALL assert o_Fifo_Read_EN for exactly one cycle, then go to LATCH unconditionally.
REQ-014 LATCH: SHALL capture i_Fifo_Data into the shift register, which accounts for the FIFO's one-cycle read latency, then go to START.
REQ-015 START: SHALL drive o_TX=0 for exactly CLKS_PER_BIT cycles.
REQ-016 DATA: SHALL send DATA_WIDTH bits LSB first, each for exactly CLKS_PER_BIT cycles, using a bit index that counts 0..DATA_WIDTH-1.
REQ-017 STOP: SHALL drive o_TX=1 for CLKS_PER_BIT cycles, pulse o_Done on its final cycle, then return to IDLE.
REQ-018 o_TX SHALL be a register updated on the same edge as the state transition, with no combinational glitches.
REQ-019 The bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL reset to 0 on every state or bit change, and SHALL terminate at CLKS_PER_BIT-1.
REQ-020 Back-to-back frames SHALL have exactly 3 idle-high cycles (IDLE, READ, LATCH) between stop-bit end and the next start bit.
REQ-021 A frame SHALL never be aborted by i_Fifo_Empty changes; at most one pop SHALL occur per frame.

Reset
REQ-022 Asserting i_RESET_n low SHALL immediately force state=IDLE, o_TX=1, o_Busy=0, o_Fifo_Read_EN=0, o_Done=0, and zero the counters and shift register.
REQ-023 Reset mid-frame SHALL drop the popped byte without retransmission; the first frame after release SHALL begin with the next FIFO entry.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and send the even-parity bit (XOR of payload) for CLKS_PER_BIT cycles.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP (8N1).

Structure
REQ-026 State encodings and UART framing constants (start=0, stop=1) SHALL reside in the shared package uart_pkg, for reuse by the receiver.
REQ-027 One sub-module, uart_baud_tick (bit-time counter emitting an end-of-bit strobe), SHALL be used; everything else stays in uart_tx.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8, driven by the team FIFO, DEPTH=16)
REQ-028 Reset held for 5 cycles -> o_TX=1, o_Busy=0, o_Fifo_Read_EN=0, o_Done=0 throughout.
REQ-029 Push 0x55 -> one read pulse; line shows 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 for 4 cycles; total 40 cycles; o_Done pulses once.
REQ-030 Push 0xA5 and 0x3C together -> exactly two read pulses, 3 idle-high cycles between frames, payloads received intact.
REQ-031 FIFO left empty for 100 cycles -> no read pulses; o_TX=1; o_Busy=0.
REQ-032 Push 0x81, 0x42; assert reset during data bit 3 of the first frame -> o_TX=1 in the same cycle; after release, the next frame carries 0x42.
REQ-033 UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 after data; push 0x55 -> parity bit 0; frame length 44 cycles.
